// File: rtl/arp_server_hls_deadlock_report_ctrl.sv
// Central deadlock controller for the ARP server dataflow region: confirms a persistent
// detect flag, launches and follows a trace token, and holds a sticky report until acked.
module arp_server_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int ID_W           = 2,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TRACE_MAX      = 255
) (
    input  logic                reset,
    input  logic                clock,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic                ack,
    output logic                dl_detect_bcast,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_found,
    output logic [ID_W-1:0]     dl_proc_id,
    output logic [PROC_NUM-1:0] dl_proc_vec
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_ORIGIN  = 3'd2,
        ST_TRACE   = 3'd3,
        ST_REPORT  = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    // cnt counts flag samples already seen, so the current sample completes the window here
    localparam logic [7:0] CONFIRM_LAST = 8'(CONFIRM_CYCLES - 1);
    localparam logic [7:0] TRACE_LAST   = 8'(TRACE_MAX);

    state_t              state_r;
    logic [ID_W-1:0]     sel_r;
    logic [7:0]          cnt_r;
    logic                bcast_r;
    logic [PROC_NUM-1:0] origin_vec_r;
    logic                token_clear_r;
    logic                dl_found_r;
    logic [ID_W-1:0]     dl_proc_id_r;
    logic [PROC_NUM-1:0] dl_proc_vec_r;
    logic                sel_hit_s;

    function automatic logic [ID_W-1:0] lowest_index(input logic [PROC_NUM-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [PROC_NUM-1:0] one_hot(input logic [ID_W-1:0] idx);
        return PROC_NUM'(1'b1) << idx;
    endfunction

    assign sel_hit_s = dl_detect_vec[sel_r];

    // Controller FSM; every output is a register updated on the transition into its state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            sel_r         <= '0;
            cnt_r         <= 8'd0;
            bcast_r       <= 1'b0;
            origin_vec_r  <= '0;
            token_clear_r <= 1'b0;
            dl_found_r    <= 1'b0;
            dl_proc_id_r  <= '0;
            dl_proc_vec_r <= '0;
        end else begin
            origin_vec_r  <= '0;
            token_clear_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|dl_detect_vec) begin
                        sel_r   <= lowest_index(dl_detect_vec);
                        cnt_r   <= 8'd1;
                        state_r <= ST_CONFIRM;
                    end else begin
                        cnt_r   <= 8'd0;
                    end
                end
                ST_CONFIRM: begin
                    if (!sel_hit_s) begin
                        sel_r   <= '0;
                        cnt_r   <= 8'd0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r >= CONFIRM_LAST) begin
                        origin_vec_r <= one_hot(sel_r);
                        bcast_r      <= 1'b1;
                        state_r      <= ST_ORIGIN;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_ORIGIN: begin
                    dl_proc_vec_r <= one_hot(sel_r);
                    cnt_r         <= 8'd0;
                    state_r       <= ST_TRACE;
                end
                ST_TRACE: begin
                    dl_proc_vec_r <= dl_proc_vec_r | dl_detect_vec;
                    // The origin's own flag in the first trace cycle is still the launch, not a return
                    if (sel_hit_s && (cnt_r != 8'd0)) begin
                        token_clear_r <= 1'b1;
                        state_r       <= ST_REPORT;
                    end else if (cnt_r >= TRACE_LAST) begin
                        dl_proc_vec_r <= '0;
                        bcast_r       <= 1'b0;
                        token_clear_r <= 1'b1;
                        sel_r         <= '0;
                        cnt_r         <= 8'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_REPORT: begin
                    dl_found_r   <= 1'b1;
                    dl_proc_id_r <= sel_r;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (ack) begin
                        dl_found_r    <= 1'b0;
                        dl_proc_id_r  <= '0;
                        dl_proc_vec_r <= '0;
                        bcast_r       <= 1'b0;
                        sel_r         <= '0;
                        cnt_r         <= 8'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    sel_r         <= '0;
                    cnt_r         <= 8'd0;
                    bcast_r       <= 1'b0;
                    dl_found_r    <= 1'b0;
                    dl_proc_id_r  <= '0;
                    dl_proc_vec_r <= '0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign dl_detect_bcast = bcast_r;
    assign origin_vec      = origin_vec_r;
    assign token_clear     = token_clear_r;
    assign dl_found        = dl_found_r;
    assign dl_proc_id      = dl_proc_id_r;
    assign dl_proc_vec     = dl_proc_vec_r;

endmodule

// File: tb/tb_arp_server_hls_deadlock_report_ctrl.sv
// Directed scoreboard bench for the deadlock report controller (CONFIRM_CYCLES=16, TRACE_MAX=8).
module tb_arp_server_hls_deadlock_report_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic       ack;
    logic       dl_detect_bcast;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       dl_found;
    logic [1:0] dl_proc_id;
    logic [3:0] dl_proc_vec;

    int checks   = 0;
    int failures = 0;
    logic [12:0] exp_q[$];

    localparam logic [12:0] Z = 13'd0;

    arp_server_hls_deadlock_report_ctrl #(
        .PROC_NUM(4), .ID_W(2), .CONFIRM_CYCLES(16), .TRACE_MAX(8)
    ) dut (
        .reset(reset), .clock(clock), .dl_detect_vec(dl_detect_vec), .ack(ack),
        .dl_detect_bcast(dl_detect_bcast), .origin_vec(origin_vec), .token_clear(token_clear),
        .dl_found(dl_found), .dl_proc_id(dl_proc_id), .dl_proc_vec(dl_proc_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Snapshot layout: {origin_vec, token_clear, bcast, dl_found, dl_proc_id, dl_proc_vec}
    function automatic logic [12:0] sn(input logic [3:0] o, input logic tc, input logic b,
                                       input logic f, input logic [1:0] id, input logic [3:0] pv);
        return {o, tc, b, f, id, pv};
    endfunction

    task automatic compare(input string tag);
        logic [12:0] e;
        logic [12:0] o;
        e = exp_q.pop_front();
        o = {origin_vec, token_clear, dl_detect_bcast, dl_found, dl_proc_id, dl_proc_vec};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_now(input string tag, input logic [12:0] e);
        exp_q.push_back(e);
        compare(tag);
    endtask

    task automatic step(input string tag, input logic [3:0] vec, input logic a, input logic [12:0] e);
        dl_detect_vec = vec;
        ack           = a;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    initial begin
        reset         = 1'b0;
        dl_detect_vec = 4'b0000;
        ack           = 1'b0;
        @(posedge clock);
        #1;
        check_now("reset_state", Z);
        reset = 1'b1;
        step("idle", 4'b0000, 1'b0, Z);

        // Basic detect on process 1, visitor 3, return at trace cycle 4
        for (int i = 1; i <= 15; i++) step("basic_confirm", 4'b0010, 1'b0, Z);
        step("basic_origin", 4'b0010, 1'b0, sn(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000));
        step("basic_launch", 4'b0010, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
        step("basic_cnt0_flag", 4'b0010, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
        step("basic_tr1", 4'b0000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
        step("basic_visit3", 4'b1000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1010));
        step("basic_tr3", 4'b0000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1010));
        step("basic_return", 4'b0010, 1'b0, sn(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1010));
        step("basic_report", 4'b1111, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1010));
        for (int i = 0; i < 3; i++)
            step("basic_hold", 4'b1111, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1010));
        step("basic_ack", 4'b0000, 1'b1, Z);
        step("basic_idle", 4'b0000, 1'b0, Z);

        // Acks outside HOLD are ignored; full confirmation restarts; trace times out
        for (int i = 1; i <= 15; i++) step("ack_confirm", 4'b0100, (i == 5 || i == 9), Z);
        step("ack_origin", 4'b0100, 1'b0, sn(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000));
        step("to_launch", 4'b0100, 1'b1, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100));
        for (int i = 0; i < 3; i++)
            step("to_trace", 4'b0000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0100));
        step("to_visit0", 4'b0001, 1'b1, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0101));
        for (int i = 4; i < 8; i++)
            step("to_trace", 4'b0000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0101));
        step("to_timeout", 4'b0000, 1'b0, sn(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        step("to_idle", 4'b0000, 1'b0, Z);

        // Glitch: 10 high, 1 low, then the full 16-sample window restarts
        for (int i = 1; i <= 10; i++) step("glitch_pre", 4'b0001, 1'b0, Z);
        step("glitch_drop", 4'b0000, 1'b0, Z);
        for (int i = 1; i <= 15; i++) step("glitch_confirm", 4'b0001, 1'b0, Z);
        step("glitch_origin", 4'b0001, 1'b0, sn(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000));
        for (int i = 0; i < 3; i++)
            step("glitch_trace", 4'b0000, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001));

        // Asynchronous reset mid-trace
        #2;
        reset = 1'b0;
        #1;
        check_now("reset_async", Z);
        for (int i = 0; i < 3; i++) step("reset_held", 4'b0000, 1'b0, Z);
        reset = 1'b1;
        step("reset_release", 4'b0000, 1'b0, Z);

        // Priority: lowest set flag wins, return detected at trace cycle 1
        for (int i = 1; i <= 15; i++) step("prio_confirm", 4'b0110, 1'b0, Z);
        step("prio_origin", 4'b0110, 1'b0, sn(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000));
        step("prio_launch", 4'b0110, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010));
        step("prio_cnt0", 4'b0110, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0110));
        step("prio_return", 4'b0110, 1'b0, sn(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0110));
        step("prio_report", 4'b0110, 1'b0, sn(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0110));
        step("prio_ack", 4'b0000, 1'b1, Z);
        step("prio_idle", 4'b0000, 1'b0, Z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
